// File: rtl/mem_responder.sv
// Single-port memory responder: sized loads/stores over a valid/ready handshake,
// with sub-word stores done as read-merge-write on a word-organised array.
module mem_responder #(
    parameter int DEPTH = 256
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP, S_ERR
    } state_t;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    logic          r_write;
    logic [1:0]    r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_data_q;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_resp_valid;
    logic          r_resp_err;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_wr_data;
    logic          w_err;

    assign w_idx     = r_addr[AW+1:2];
    assign w_rd_word = r_mem[w_idx];
    assign w_wr_data = (r_size == 2'b00) ? r_wdata : r_data_q;

    assign w_err = (i_req_size == 2'b11)
                || (i_req_size == 2'b00 && i_req_addr[1:0] != 2'b00)
                || (i_req_size == 2'b01 && i_req_addr[0])
                || (i_req_addr[31:AW+2] != '0);

    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   return word;
            2'b01:   return off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
            default: return {24'h0, sh[7:0]};
        endcase
    endfunction

    // Lane mask selects the addressed byte/half; everything else is kept.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [31:0] wdata,
                                            input logic [1:0]  size,
                                            input logic [1:0]  off);
        logic [4:0]  shamt;
        logic [31:0] mask;
        if (size == 2'b01) begin
            shamt = {off[1], 4'b0000};
            mask  = 32'h0000_FFFF << shamt;
        end else begin
            shamt = {off, 3'b000};
            mask  = 32'h0000_00FF << shamt;
        end
        return (word & ~mask) | ((wdata << shamt) & mask);
    endfunction

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
            r_data_q     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write <= i_req_write;
                        r_size  <= i_req_size;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_ready <= 1'b0;
                        if (w_err) begin
                            r_state      <= S_ERR;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (i_req_write && i_req_size == 2'b00) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_data_q <= w_rd_word;
                    if (r_write) begin
                        r_state <= S_MERGE;
                    end else begin
                        // Extract alongside the data_q capture so rdata is registered in RESP.
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= f_extract(w_rd_word, r_size, r_addr[1:0]);
                    end
                end
                S_MERGE: begin
                    r_data_q <= f_merge(r_data_q, r_wdata, r_size, r_addr[1:0]);
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                S_RESP, S_ERR: begin
                    r_state      <= S_IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_rdata      <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Array is never reset; a reset edge suppresses the pending write.
    always_ff @(posedge i_clock) begin
        if (i_reset && r_state == S_WRITE) begin
            r_mem[w_idx] <= w_wr_data;
        end
    end

    assign o_req_ready  = r_ready;
    assign o_busy       = ~r_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_rdata = r_rdata;

endmodule
